fpcvt_serial: RTL

//  Parametrised two's-complement integer to sign/exponent/mantissa float converter.

---
 rtl/fpcvt_serial.sv | 90 +++++++++
 1 files changed

// File: rtl/fpcvt_serial.sv
// fpcvt_serial: serial two's-complement integer to sign/exponent/mantissa float converter
// Define FPCVT_SAT_FLAG_EN to add the out_sat saturation flag port.
module fpcvt_serial #(
    parameter int IN_W  = 12,
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_man
`ifdef FPCVT_SAT_FLAG_EN
    ,
    output logic             out_sat
`endif
);
    localparam int SH_MAX = IN_W - MAN_W;
    localparam int CNT_W  = $clog2(SH_MAX + 1);
    localparam int E1     = EXP_W + 1;
    localparam logic [1:0] IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3;

    logic [1:0]       state;
    logic [IN_W-1:0]  mag;
    logic [CNT_W-1:0] cnt;
    logic             sign;
    logic [E1-1:0]    e_raw, e_fin;
    logic [MAN_W:0]   f_inc;
    logic [MAN_W-1:0] f_fin;
    logic             r, sat, cnt_max;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign cnt_max   = cnt == CNT_W'(SH_MAX);

    // Round half-up on the first dropped bit; a mantissa carry bumps the exponent.
    always_comb begin
        e_raw = E1'(SH_MAX) - E1'(cnt);
        r     = !cnt_max && mag[IN_W-1-MAN_W];
        f_inc = {1'b0, mag[IN_W-1 -: MAN_W]} + (MAN_W+1)'(r);
        e_fin = f_inc[MAN_W] ? e_raw + E1'(1) : e_raw;
        f_fin = f_inc[MAN_W] ? f_inc[MAN_W:1] : f_inc[MAN_W-1:0];
        sat   = e_fin > E1'((1 << EXP_W) - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sign     <= 1'b0;
            mag      <= '0;
            cnt      <= '0;
            out_sign <= 1'b0;
            out_exp  <= '0;
            out_man  <= '0;
`ifdef FPCVT_SAT_FLAG_EN
            out_sat  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= NORM;
                    sign  <= in_data[IN_W-1];
                    mag   <= in_data[IN_W-1] ? -in_data : in_data;
                    cnt   <= '0;
                end
                NORM: if (mag[IN_W-1] || cnt_max) begin
                    state <= ROUND;
                end else begin
                    mag <= mag << 1;
                    cnt <= cnt + CNT_W'(1);
                end
                ROUND: begin
                    state    <= DONE;
                    out_sign <= sign;
                    out_exp  <= sat ? '1 : e_fin[EXP_W-1:0];
                    out_man  <= sat ? '1 : f_fin;
`ifdef FPCVT_SAT_FLAG_EN
                    out_sat  <= sat;
`endif
                end
                DONE: if (out_ready) state <= IDLE;
            endcase
        end
    end
endmodule
